// File: rtl/ac2_mul_pkg.sv
// Shared types and helpers for the ac2 sequential approximate multiplier.
//   state_e   : controller states (idle, accumulate, final add, result held)
//   cnt_width : width of the ACCUM step counter for a given operand width
package ac2_mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StFinal,
        StDone
    } state_e;

    // Counter must hold 0 .. w/2-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w / 2 > 1) ? $clog2(w / 2) : 1;
    endfunction

endpackage

// File: rtl/ac2_col_compress.sv
// Bank of L approximate 4:2 compressor cells, one per accumulator column.
//   p0_i, p1_i : partial-product row bits (q1, q2)
//   s_i, c_i   : running sum / carry vector bits (q3, q4)
//   s_o        : per-column sum
//   c_o        : per-column carry (unshifted; caller moves it up one column)
// The q3=q4=1, q1=q2=0 case produces no carry; that loss is intentional.
module ac2_col_compress #(
    parameter int unsigned L = 8
) (
    input  logic [L-1:0] p0_i,
    input  logic [L-1:0] p1_i,
    input  logic [L-1:0] s_i,
    input  logic [L-1:0] c_i,
    output logic [L-1:0] s_o,
    output logic [L-1:0] c_o
);

    always_comb begin
        s_o = p0_i ^ p1_i ^ s_i ^ c_i;
        c_o = (p0_i & p1_i) | ((p0_i ^ p1_i) & (s_i ^ c_i));
    end

endmodule

// File: rtl/ac2_seq_mul.sv
// Iterative approximate unsigned multiplier, W x W -> 2W, two multiplier bits per cycle.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid_i/in_ready_o   : operand handshake (ready only when idle)
//   a_i, b_i            : multiplicand / multiplier
//   exact_mode_i        : 1 forces fully exact reduction for this operation
//   out_valid_o/out_ready_i : result handshake
//   product_o           : result, stable while out_valid_o is high
// The low APPROX_BITS columns are reduced by approximate 4:2 cells, the rest by an exact adder.
module ac2_seq_mul
    import ac2_mul_pkg::*;
#(
    parameter int unsigned W           = 8,
    parameter int unsigned APPROX_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    input  logic            exact_mode_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [2*W-1:0]  product_o
);

    localparam int unsigned DW = 2 * W;
    localparam int unsigned CW = cnt_width(W);
    localparam int unsigned L  = APPROX_BITS;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            exact_q, exact_d;
    logic [DW-1:0]   s_q, s_d, c_q, c_d;
    logic [CW-1:0]   k_q, k_d;
    logic [DW-1:0]   product_q, product_d;

    logic            last_step;
    logic [CW:0]     idx0, idx1;
    logic [DW-1:0]   a_ext, p0, p1;
    logic [DW-1:0]   exact_sum, apx_s, apx_c, red_s, red_c;

    assign last_step = (k_q == CW'(W / 2 - 1));
    assign idx0      = {k_q, 1'b0};
    assign idx1      = {k_q, 1'b1};
    assign a_ext     = {{W{1'b0}}, a_q};
    assign p0        = b_q[idx0] ? (a_ext << idx0) : '0;
    assign p1        = b_q[idx1] ? (a_ext << idx1) : '0;
    assign exact_sum = s_q + c_q + p0 + p1;

    if (L == 0) begin : g_no_apx
        assign apx_s = exact_sum;
        assign apx_c = '0;
    end else begin : g_apx
        logic [L-1:0] cmp_s, cmp_c, lo_c;

        ac2_col_compress #(
            .L (L)
        ) u_col_compress (
            .p0_i (p0[L-1:0]),
            .p1_i (p1[L-1:0]),
            .s_i  (s_q[L-1:0]),
            .c_i  (c_q[L-1:0]),
            .s_o  (cmp_s),
            .c_o  (cmp_c)
        );

        // Carries move up one column; the top column's carry leaves the approximate region.
        assign lo_c = cmp_c << 1;

        if (L >= DW) begin : g_full
            assign apx_s = cmp_s;
            assign apx_c = lo_c;
        end else begin : g_split
            localparam int unsigned HW = DW - L;
            logic [HW-1:0] hi_sum;

            assign hi_sum = s_q[DW-1:L] + c_q[DW-1:L] + p0[DW-1:L] + p1[DW-1:L]
                          + HW'(cmp_c[L-1]);
            assign apx_s  = {hi_sum, cmp_s};
            assign apx_c  = {{HW{1'b0}}, lo_c};
        end
    end

    always_comb begin
        if (exact_q || (L == 0)) begin
            red_s = exact_sum;
            red_c = '0;
        end else begin
            red_s = apx_s;
            red_c = apx_c;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid_i) state_d = StAccum;
            StAccum: if (last_step) state_d = StFinal;
            StFinal: state_d = StDone;
            StDone:  if (out_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        product_o   = product_q;
    end

    // Datapath next state
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        exact_d   = exact_q;
        s_d       = s_q;
        c_d       = c_q;
        k_d       = k_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    exact_d = exact_mode_i;
                    s_d     = '0;
                    c_d     = '0;
                    k_d     = '0;
                end
            end
            StAccum: begin
                s_d = red_s;
                c_d = red_c;
                k_d = k_q + 1'b1;
            end
            StFinal: product_d = s_q + c_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            exact_q   <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            k_q       <= '0;
            product_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            exact_q   <= exact_d;
            s_q       <= s_d;
            c_q       <= c_d;
            k_q       <= k_d;
            product_q <= product_d;
        end
    end

endmodule

// File: tb/tb_ac2_seq_mul.sv
// Self-checking bench: five W=8 instances with APPROX_BITS 0/2/4/8/16 share one stimulus
// stream; a bench-side model predicts each product and a negedge process compares.
module tb_ac2_seq_mul;

    localparam int NDUT = 5;

    function automatic int unsigned lsel(input int g);
        case (g)
            0:       return 0;
            1:       return 2;
            2:       return 4;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          a = '0;
    logic [7:0]          b = '0;
    logic                exact_mode = 1'b0;
    logic                out_ready = 1'b0;
    logic [NDUT-1:0]     ir, ov;
    logic [15:0]         prod [NDUT];
    logic [15:0]         exp_v [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ac2_seq_mul #(
            .W           (8),
            .APPROX_BITS (lsel(g))
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .in_valid_i   (in_valid),
            .in_ready_o   (ir[g]),
            .a_i          (a),
            .b_i          (b),
            .exact_mode_i (exact_mode),
            .out_valid_o  (ov[g]),
            .out_ready_i  (out_ready),
            .product_o    (prod[g])
        );
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Column-by-column restatement of the reduction rules, on plain integers.
    function automatic logic [15:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic ex, input int unsigned l);
        int unsigned s, c, p0, p1, sn, cn, cin, hi, q1, q2, q3, q4, cb;
        s = 0;
        c = 0;
        for (int k = 0; k < 4; k++) begin
            p0 = mb[2*k]   ? (int'(ma) << (2*k))   : 0;
            p1 = mb[2*k+1] ? (int'(ma) << (2*k+1)) : 0;
            if (ex || l == 0) begin
                s = (s + c + p0 + p1) & 32'hFFFF;
                c = 0;
            end else begin
                sn  = 0;
                cn  = 0;
                cin = 0;
                for (int i = 0; i < int'(l); i++) begin
                    q1 = (p0 >> i) & 1;
                    q2 = (p1 >> i) & 1;
                    q3 = (s >> i) & 1;
                    q4 = (c >> i) & 1;
                    sn |= (q1 ^ q2 ^ q3 ^ q4) << i;
                    cb = (q1 & q2) | ((q1 ^ q2) & (q3 ^ q4));
                    if (i + 1 < int'(l)) cn |= cb << (i + 1);
                    else cin = cb;
                end
                if (l < 16) begin
                    hi = (s >> l) + (c >> l) + (p0 >> l) + (p1 >> l) + cin;
                    sn |= (hi << l) & 32'hFFFF;
                end
                s = sn;
                c = cn;
            end
        end
        return 16'((s + c) & 32'hFFFF);
    endfunction

    // Compare every cycle a result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < NDUT; g++) begin
                if (ov[g]) begin
                    check($sformatf("product L=%0d", lsel(g)), 32'(prod[g]), 32'(exp_v[g]));
                    check($sformatf("in_ready while valid L=%0d", lsel(g)), 32'(ir[g]), 0);
                end
            end
        end
    end

    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tex);
        int n;
        n = 0;
        while (!ir[0] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check("in_ready timeout", 32'(ir[0]), 1);
        for (int g = 0; g < NDUT; g++) begin
            exp_v[g] = (lsel(g) == 0) ? 16'(32'(ta) * 32'(tb)) : model(ta, tb, tex, lsel(g));
        end
        a          = ta;
        b          = tb;
        exact_mode = tex;
        in_valid   = 1'b1;
        out_ready  = 1'b0;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        // Operands change after acceptance; the result must not see them.
        a          = 8'($urandom);
        b          = 8'($urandom);
        exact_mode = 1'($urandom);
    endtask

    // Handshake cycle + 4 ACCUM + FINAL = W/2+2 cycles: out_valid is seen 5 edges
    // after the accepting edge.
    task automatic wait_done();
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (ov[0]) break;
        end
        check("latency edges", n, 5);
    endtask

    task automatic finish_op(input int hold);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("held in_ready", 32'(ir), 0);
            check("held out_valid", 32'(ov), 32'({NDUT{1'b1}}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post-transfer out_valid", 32'(ov), 0);
        check("post-transfer in_ready", 32'(ir), 32'({NDUT{1'b1}}));
    endtask

    task automatic full_op(input logic [7:0] ta, input logic [7:0] tb, input logic tex,
                           input int hold);
        start_op(ta, tb, tex);
        wait_done();
        finish_op(hold);
    endtask

    initial begin
        for (int g = 0; g < NDUT; g++) exp_v[g] = '0;

        // Hand-computed pins on the model
        check("model 3x3 L=2", 32'(model(8'd3, 8'd3, 1'b0, 2)), 9);
        check("model 3x3 L=16", 32'(model(8'd3, 8'd3, 1'b0, 16)), 1);
        check("model 3x3 L=16 exact", 32'(model(8'd3, 8'd3, 1'b1, 16)), 9);
        check("model 255x255 exact", 32'(model(8'd255, 8'd255, 1'b1, 8)), 65025);

        // Reset state
        #12;
        check("reset in_ready", 32'(ir), 32'({NDUT{1'b1}}));
        check("reset out_valid", 32'(ov), 0);
        for (int g = 0; g < NDUT; g++) check("reset product", 32'(prod[g]), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: 3x3 approximate
        start_op(8'd3, 8'd3, 1'b0);
        wait_done();
        check("3x3 L=2", 32'(prod[1]), 9);
        check("3x3 L=16", 32'(prod[4]), 1);
        check("3x3 L=0", 32'(prod[0]), 9);
        finish_op(0);

        // Same operands, exact
        start_op(8'd3, 8'd3, 1'b1);
        wait_done();
        check("3x3 exact L=16", 32'(prod[4]), 9);
        finish_op(0);

        // 255x255 exact with back-pressure held 5 cycles
        start_op(8'd255, 8'd255, 1'b1);
        wait_done();
        check("255x255 exact L=8", 32'(prod[3]), 65025);
        finish_op(5);

        // Asynchronous reset during ACCUM k=2
        start_op(8'd200, 8'd173, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-op reset out_valid", 32'(ov), 0);
        check("mid-op reset in_ready", 32'(ir), 32'({NDUT{1'b1}}));
        for (int g = 0; g < NDUT; g++) check("mid-op reset product", 32'(prod[g]), 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("no result after reset", 32'(ov), 0);
        end

        start_op(8'd7, 8'd9, 1'b1);
        wait_done();
        for (int g = 0; g < NDUT; g++) check("7x9 exact", 32'(prod[g]), 63);
        finish_op(0);

        // Edge operands and random sweep
        full_op(8'd0, 8'd255, 1'b0, 0);
        full_op(8'd255, 8'd255, 1'b0, 0);
        full_op(8'd128, 8'd1, 1'b0, 2);
        for (int i = 0; i < 4000; i++) begin
            full_op(8'($urandom), 8'($urandom), 1'($urandom), (i % 97 == 0) ? 3 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
